// File: rtl/reservation_station.sv
// reservation_station: Tomasulo unified reservation station that buffers micro-ops, snoops the CDB and issues one ready op per cycle
// Ports:
//   i_clk, i_rst (sync active-high), i_pause (freeze), i_flush (clear all entries)
//   i_in_*   : dispatched micro-op (i_in_op == 5'b11111 means none)
//   i_cdb_*  : result broadcast (valid, tag, value)
//   i_alu_ready : ALU accepts an issue this cycle
//   o_rs_full   : registered, occupancy >= DEPTH-1
//   o_issue_*   : registered issue to the ALU
// Optional feature: define RS_WAKEUP_BYPASS_EN to let an entry woken by this cycle's CDB issue on the same edge.
module reservation_station #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pause,
    input  logic             i_flush,
    input  logic [4:0]       i_in_op,
    input  logic [31:0]      i_in_vj,
    input  logic [31:0]      i_in_vk,
    input  logic [TAG_W-1:0] i_in_qj,
    input  logic [TAG_W-1:0] i_in_qk,
    input  logic             i_in_qj_busy,
    input  logic             i_in_qk_busy,
    input  logic [TAG_W-1:0] i_in_dest,
    input  logic             i_cdb_valid,
    input  logic [TAG_W-1:0] i_cdb_tag,
    input  logic [31:0]      i_cdb_value,
    input  logic             i_alu_ready,
    output logic             o_rs_full,
    output logic [4:0]       o_issue_op,
    output logic [31:0]      o_issue_vj,
    output logic [31:0]      o_issue_vk,
    output logic [TAG_W-1:0] o_issue_dest,
    output logic             o_issue_valid
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [4:0] NOP = 5'b11111;
    localparam logic [DEPTH-1:0] ONE = {{(DEPTH-1){1'b0}}, 1'b1};

    logic [DEPTH-1:0] r_busy, r_qj_busy, r_qk_busy;
    logic [4:0]       r_op   [DEPTH];
    logic [31:0]      r_vj   [DEPTH];
    logic [31:0]      r_vk   [DEPTH];
    logic [TAG_W-1:0] r_qj   [DEPTH];
    logic [TAG_W-1:0] r_qk   [DEPTH];
    logic [TAG_W-1:0] r_dest [DEPTH];

    logic             r_rs_full, r_issue_valid;
    logic [4:0]       r_issue_op;
    logic [31:0]      r_issue_vj, r_issue_vk;
    logic [TAG_W-1:0] r_issue_dest;

    logic [DEPTH-1:0] w_j_hit, w_k_hit, w_ready, w_busy_nxt, w_iss_mask, w_ins_mask;
    logic [IW-1:0]    w_free_idx, w_sel_idx;
    logic             w_has_free, w_any_ready, w_sel, w_ins, w_in_j_cap, w_in_k_cap;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_j_hit[i] = i_cdb_valid && r_busy[i] && r_qj_busy[i] && r_qj[i] == i_cdb_tag;
            w_k_hit[i] = i_cdb_valid && r_busy[i] && r_qk_busy[i] && r_qk[i] == i_cdb_tag;
`ifdef RS_WAKEUP_BYPASS_EN
            w_ready[i] = r_busy[i] && (!r_qj_busy[i] || w_j_hit[i]) && (!r_qk_busy[i] || w_k_hit[i]);
`else
            w_ready[i] = r_busy[i] && !r_qj_busy[i] && !r_qk_busy[i];
`endif
        end
    end

    // Descending scan so the last assignment wins: lowest free slot, lowest ready slot.
    always_comb begin
        w_free_idx  = '0;
        w_has_free  = 1'b0;
        w_sel_idx   = '0;
        w_any_ready = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_idx = IW'(i);
                w_has_free = 1'b1;
            end
            if (w_ready[i]) begin
                w_sel_idx   = IW'(i);
                w_any_ready = 1'b1;
            end
        end
    end

    assign w_sel      = w_any_ready && i_alu_ready;
    assign w_ins      = i_in_op != NOP && w_has_free;
    assign w_in_j_cap = i_in_qj_busy && i_cdb_valid && i_cdb_tag == i_in_qj;
    assign w_in_k_cap = i_in_qk_busy && i_cdb_valid && i_cdb_tag == i_in_qk;
    assign w_iss_mask = w_sel ? ONE << w_sel_idx : '0;
    assign w_ins_mask = w_ins ? ONE << w_free_idx : '0;
    // The insert slot was free before the edge, so it never collides with the issuing slot.
    assign w_busy_nxt = (r_busy & ~w_iss_mask) | w_ins_mask;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy        <= '0;
            r_rs_full     <= 1'b0;
            r_issue_valid <= 1'b0;
            r_issue_op    <= NOP;
            r_issue_vj    <= '0;
            r_issue_vk    <= '0;
            r_issue_dest  <= '0;
        end else if (i_flush) begin
            r_busy        <= '0;
            r_rs_full     <= 1'b0;
            r_issue_valid <= 1'b0;
            r_issue_op    <= NOP;
        end else if (!i_pause) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_j_hit[i]) begin
                    r_vj[i]      <= i_cdb_value;
                    r_qj_busy[i] <= 1'b0;
                end
                if (w_k_hit[i]) begin
                    r_vk[i]      <= i_cdb_value;
                    r_qk_busy[i] <= 1'b0;
                end
            end
            if (w_ins) begin
                r_op[w_free_idx]      <= i_in_op;
                r_vj[w_free_idx]      <= w_in_j_cap ? i_cdb_value : i_in_vj;
                r_vk[w_free_idx]      <= w_in_k_cap ? i_cdb_value : i_in_vk;
                r_qj[w_free_idx]      <= i_in_qj;
                r_qk[w_free_idx]      <= i_in_qk;
                r_qj_busy[w_free_idx] <= i_in_qj_busy && !w_in_j_cap;
                r_qk_busy[w_free_idx] <= i_in_qk_busy && !w_in_k_cap;
                r_dest[w_free_idx]    <= i_in_dest;
            end
            r_issue_valid <= w_sel;
            r_issue_op    <= w_sel ? r_op[w_sel_idx] : NOP;
            if (w_sel) begin
                // A hit on the selected entry only occurs with bypass; then the CDB value is the operand.
                r_issue_vj   <= w_j_hit[w_sel_idx] ? i_cdb_value : r_vj[w_sel_idx];
                r_issue_vk   <= w_k_hit[w_sel_idx] ? i_cdb_value : r_vk[w_sel_idx];
                r_issue_dest <= r_dest[w_sel_idx];
            end
            r_busy    <= w_busy_nxt;
            r_rs_full <= $countones(w_busy_nxt) >= DEPTH - 1;
        end
    end

    assign o_rs_full     = r_rs_full;
    assign o_issue_valid = r_issue_valid;
    assign o_issue_op    = r_issue_op;
    assign o_issue_vj    = r_issue_vj;
    assign o_issue_vk    = r_issue_vk;
    assign o_issue_dest  = r_issue_dest;
endmodule
